// File: rtl/btb_update_queue_pkg.sv
// Shared types and defaults for the BTB update queue: address type, queue entry
// record, default sizing, and the per-lane "BTB needs a write" predicate.
package btb_update_queue_pkg;

  localparam int ADDR_W                 = 32;
  localparam int RETIRE_WIDTH_DEF       = 4;
  localparam int BTB_UPDATE_QUEUE_DEPTH = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    addr_t pc;
    addr_t target;
  } btb_upd_entry_t;

  // A retiring branch needs a BTB write only if it was taken and the BTB
  // either missed or supplied the wrong target.
  function automatic logic lane_qualifies(input logic  valid,
                                          input logic  taken,
                                          input logic  btb_hit,
                                          input addr_t pred_target,
                                          input addr_t target);
    return valid & taken & (~btb_hit | (pred_target != target));
  endfunction

endpackage

// File: rtl/btb_upd_compact.sv
// Qualify, coalesce and compact one cycle of retiring branch lanes into a
// dense list of BTB update records (oldest first) plus a record count.
module btb_upd_compact
  import btb_update_queue_pkg::*;
#(
  parameter int RETIRE_WIDTH = RETIRE_WIDTH_DEF,
  parameter int RW           = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic                                 [RETIRE_WIDTH-1:0] rt_valid,
  input  logic                                 [RETIRE_WIDTH-1:0] rt_taken,
  input  addr_t          [RETIRE_WIDTH-1:0]                       rt_pc,
  input  addr_t          [RETIRE_WIDTH-1:0]                       rt_target,
  input  logic                                 [RETIRE_WIDTH-1:0] rt_btb_hit,
  input  addr_t          [RETIRE_WIDTH-1:0]                       rt_pred_target,
  output btb_upd_entry_t [RETIRE_WIDTH-1:0]                       recs,
  output logic                                 [RW-1:0]           n_rec
);

  localparam int IW = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1;

  logic  [RETIRE_WIDTH-1:0] qual;
  logic  [RETIRE_WIDTH-1:0] first;
  addr_t [RETIRE_WIDTH-1:0] merged_tgt;
  logic  [IW-1:0]           slot;

  // A lane owns a slot only if no older qualifying lane has the same PC; the
  // owning slot takes the target of the youngest lane sharing that PC.
  always_comb begin
    qual       = '0;
    first      = '0;
    merged_tgt = '0;
    recs       = '0;
    n_rec      = '0;
    slot       = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      qual[j] = lane_qualifies(rt_valid[j], rt_taken[j], rt_btb_hit[j],
                               rt_pred_target[j], rt_target[j]);
    end
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      first[j]      = qual[j];
      merged_tgt[j] = rt_target[j];
      for (int i = 0; i < j; i++) begin
        if (qual[i] && (rt_pc[i] == rt_pc[j])) first[j] = 1'b0;
      end
      for (int k = j + 1; k < RETIRE_WIDTH; k++) begin
        if (qual[k] && (rt_pc[k] == rt_pc[j])) merged_tgt[j] = rt_target[k];
      end
    end
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      if (first[j]) begin
        recs[slot].pc     = rt_pc[j];
        recs[slot].target = merged_tgt[j];
        slot              = slot + IW'(1);
        n_rec             = n_rec + RW'(1);
      end
    end
  end

endmodule

// File: rtl/btb_update_queue.sv
// Circular queue between retire and the single BTB write port. Accepts up to
// RETIRE_WIDTH coalesced records per cycle, writes one per cycle, and counts
// records dropped for lack of space (saturating). Retire is never stalled.
module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int RETIRE_WIDTH  = RETIRE_WIDTH_DEF,
  parameter int DEPTH         = BTB_UPDATE_QUEUE_DEPTH,
  parameter int DROP_CNT_BITS = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic  [RETIRE_WIDTH-1:0]             rt_valid,
  input  logic  [RETIRE_WIDTH-1:0]             rt_taken,
  input  addr_t [RETIRE_WIDTH-1:0]             rt_pc,
  input  addr_t [RETIRE_WIDTH-1:0]             rt_target,
  input  logic  [RETIRE_WIDTH-1:0]             rt_btb_hit,
  input  addr_t [RETIRE_WIDTH-1:0]             rt_pred_target,
  output logic                                 wr_en,
  output addr_t                                wr_pc,
  output addr_t                                wr_target,
  output logic  [$clog2(DEPTH):0]              count,
  output logic                                 full,
  output logic  [DROP_CNT_BITS-1:0]            drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(RETIRE_WIDTH + 1);
  localparam int DW = DROP_CNT_BITS + CW;

  btb_upd_entry_t                    mem [DEPTH];
  btb_upd_entry_t [RETIRE_WIDTH-1:0] recs;
  logic [RW-1:0]                     n_rec;
  logic [PW-1:0]                     head;
  logic [PW-1:0]                     tail;
  logic [CW-1:0]                     free_slots;
  logic [CW-1:0]                     n_rec_x;
  logic [CW-1:0]                     n_acc;
  logic [CW-1:0]                     n_drop;
  logic [DW-1:0]                     drop_sum;
  logic [DROP_CNT_BITS-1:0]          drop_nxt;

  btb_upd_compact #(
    .RETIRE_WIDTH (RETIRE_WIDTH),
    .RW           (RW)
  ) u_compact (
    .rt_valid       (rt_valid),
    .rt_taken       (rt_taken),
    .rt_pc          (rt_pc),
    .rt_target      (rt_target),
    .rt_btb_hit     (rt_btb_hit),
    .rt_pred_target (rt_pred_target),
    .recs           (recs),
    .n_rec          (n_rec)
  );

  // Head drives the BTB directly; outputs are masked to zero when empty.
  always_comb begin
    wr_en     = (count != '0);
    full      = (count == CW'(DEPTH));
    wr_pc     = wr_en ? mem[head].pc     : '0;
    wr_target = wr_en ? mem[head].target : '0;
  end

  // The head slot frees up in the same cycle it is written, so a full queue
  // still has one slot; excess records are dropped youngest first.
  always_comb begin
    n_rec_x    = CW'(n_rec);
    free_slots = CW'(DEPTH) - count + CW'(wr_en);
    n_acc      = (n_rec_x < free_slots) ? n_rec_x : free_slots;
    n_drop     = n_rec_x - n_acc;
    drop_sum   = DW'(drop_count) + DW'(n_drop);
    drop_nxt   = (drop_sum > DW'({DROP_CNT_BITS{1'b1}})) ? {DROP_CNT_BITS{1'b1}}
                                                         : drop_sum[DROP_CNT_BITS-1:0];
  end

  // Entry storage: accepted records land at consecutive slots from tail.
  always_ff @(posedge clock) begin
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (CW'(k) < n_acc) mem[tail + PW'(k)] <= recs[k];
    end
  end

  // Pointers, occupancy and drop counter; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      head       <= head + PW'(wr_en);
      tail       <= tail + PW'(n_acc);
      count      <= count - CW'(wr_en) + n_acc;
      drop_count <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed + random bench for btb_update_queue against a queue-based model.
module tb_btb_update_queue;
  import btb_update_queue_pkg::*;

  localparam int NL    = 4;
  localparam int DEPTH = 8;
  localparam int DCB   = 8;

  logic                  clock;
  logic                  reset;
  logic [NL-1:0]         rt_valid, rt_taken, rt_btb_hit;
  logic [NL-1:0][31:0]   rt_pc, rt_target, rt_pred_target;
  logic                  wr_en, full;
  logic [31:0]           wr_pc, wr_target;
  logic [$clog2(DEPTH):0] count;
  logic [DCB-1:0]        drop_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mq_pc[$];
  logic [31:0] mq_tg[$];
  int          m_drop;

  btb_update_queue #(.RETIRE_WIDTH(NL), .DEPTH(DEPTH), .DROP_CNT_BITS(DCB)) dut (
    .clock          (clock),
    .reset          (reset),
    .rt_valid       (rt_valid),
    .rt_taken       (rt_taken),
    .rt_pc          (rt_pc),
    .rt_target      (rt_target),
    .rt_btb_hit     (rt_btb_hit),
    .rt_pred_target (rt_pred_target),
    .wr_en          (wr_en),
    .wr_pc          (wr_pc),
    .wr_target      (wr_target),
    .count          (count),
    .full           (full),
    .drop_count     (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("wr_en",      64'(wr_en),      64'(mq_pc.size() != 0));
    check("wr_pc",      64'(wr_pc),      64'((mq_pc.size() != 0) ? mq_pc[0] : 32'h0));
    check("wr_target",  64'(wr_target),  64'((mq_tg.size() != 0) ? mq_tg[0] : 32'h0));
    check("count",      64'(count),      64'(mq_pc.size()));
    check("full",       64'(full),       64'(mq_pc.size() == DEPTH));
    check("drop_count", 64'(drop_count), 64'(m_drop));
  endtask

  // Reference behaviour of one clock edge, from the current inputs.
  task automatic model_edge();
    logic [31:0] rp[$];
    logic [31:0] rt[$];
    int          found;
    if (mq_pc.size() != 0) begin
      void'(mq_pc.pop_front());
      void'(mq_tg.pop_front());
    end
    for (int i = 0; i < NL; i++) begin
      if (rt_valid[i] && rt_taken[i] &&
          (!rt_btb_hit[i] || rt_pred_target[i] != rt_target[i])) begin
        found = -1;
        foreach (rp[k]) if (found < 0 && rp[k] == rt_pc[i]) found = k;
        if (found >= 0) rt[found] = rt_target[i];
        else begin
          rp.push_back(rt_pc[i]);
          rt.push_back(rt_target[i]);
        end
      end
    end
    foreach (rp[k]) begin
      if (mq_pc.size() < DEPTH) begin
        mq_pc.push_back(rp[k]);
        mq_tg.push_back(rt[k]);
      end else if (m_drop < (1 << DCB) - 1) begin
        m_drop++;
      end
    end
  endtask

  task automatic step();
    check_model();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    rt_valid = '0; rt_taken = '0; rt_btb_hit = '0;
    rt_pc = '0; rt_target = '0; rt_pred_target = '0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic taken, input logic hit, input logic [31:0] pred);
    rt_valid[i] = 1'b1; rt_taken[i] = taken; rt_btb_hit[i] = hit;
    rt_pc[i] = pc; rt_target[i] = tgt; rt_pred_target[i] = pred;
  endtask

  initial begin
    int n;
    m_drop = 0;
    set_idle();
    reset = 1'b0;
    #2;
    check("reset_wr_en", 64'(wr_en), 64'(0));
    check("reset_count", 64'(count), 64'(0));
    check("reset_full",  64'(full),  64'(0));
    check("reset_drop",  64'(drop_count), 64'(0));
    #5 reset = 1'b1;
    @(posedge clock); #1;

    // single miss: visible next cycle, gone the cycle after
    set_lane(0, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    step();
    set_idle();
    check("miss_wr_en",  64'(wr_en), 64'(1));
    check("miss_pc",     64'(wr_pc), 64'(32'h100));
    check("miss_target", 64'(wr_target), 64'(32'h200));
    step();
    check("miss_drained_en", 64'(wr_en), 64'(0));
    check("miss_drained_ct", 64'(count), 64'(0));

    // correct hit and not-taken lanes are filtered
    set_lane(0, 32'h500, 32'h300, 1'b1, 1'b1, 32'h300);
    set_lane(1, 32'h600, 32'h700, 1'b0, 1'b0, 32'h0);
    step();
    set_idle();
    check("filter_count", 64'(count), 64'(0));
    check("filter_drop",  64'(drop_count), 64'(0));

    // same-PC coalesce, youngest target wins
    set_lane(0, 32'h40, 32'h80, 1'b1, 1'b0, 32'h0);
    set_lane(1, 32'h40, 32'hC0, 1'b1, 1'b1, 32'h80);
    step();
    set_idle();
    check("coal_count",  64'(count), 64'(1));
    check("coal_pc",     64'(wr_pc), 64'(32'h40));
    check("coal_target", 64'(wr_target), 64'(32'hC0));
    step();

    // fill exactly to DEPTH without dropping
    for (int it = 0; it < 10 && mq_pc.size() < DEPTH; it++) begin
      n = DEPTH - mq_pc.size() + ((mq_pc.size() != 0) ? 1 : 0);
      if (n > NL) n = NL;
      set_idle();
      for (int i = 0; i < n; i++) set_lane(i, 32'h1000 + 32'(it * 16 + i * 4), 32'h9000 + 32'(it * 4 + i), 1'b1, 1'b0, 32'h0);
      step();
    end
    set_idle();
    check("fill_full",  64'(full), 64'(1));
    check("fill_drop",  64'(drop_count), 64'(0));
    set_lane(0, 32'h2000, 32'h2100, 1'b1, 1'b0, 32'h0);
    set_lane(1, 32'h2004, 32'h2104, 1'b1, 1'b0, 32'h0);
    step();
    set_idle();
    check("ovf_count", 64'(count), 64'(8));
    check("ovf_full",  64'(full), 64'(1));
    check("ovf_drop",  64'(drop_count), 64'(1));

    // sustained overflow saturates the drop counter
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NL; i++) set_lane(i, 32'h3000 + 32'(i * 4), 32'h4000 + 32'(c), 1'b1, 1'b0, 32'h0);
      step();
    end
    set_idle();
    check("sat_drop", 64'(drop_count), 64'(8'hFF));

    // drain to 5, then async reset mid-drain
    for (int it = 0; it < 10 && mq_pc.size() > 5; it++) step();
    check("pre_reset_count", 64'(count), 64'(5));
    #2 reset = 1'b0;
    #1;
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_full",  64'(full),  64'(0));
    check("rst_drop",  64'(drop_count), 64'(0));
    mq_pc.delete(); mq_tg.delete(); m_drop = 0;
    #3 reset = 1'b1;
    @(posedge clock); #1;

    // single enqueues across pointer wrap, written in order
    for (int i = 0; i < 3 * DEPTH; i++) begin
      set_idle();
      set_lane(0, 32'h5000 + 32'(i * 4), 32'h6000 + 32'(i), 1'b1, 1'b0, 32'h0);
      step();
      check("wrap_pc",  64'(wr_pc), 64'(32'h5000 + 32'(i * 4)));
      check("wrap_tgt", 64'(wr_target), 64'(32'h6000 + 32'(i)));
    end
    set_idle();
    step();

    // random traffic over a small PC space to exercise coalescing and drops
    for (int c = 0; c < 400; c++) begin
      set_idle();
      for (int i = 0; i < NL; i++) begin
        rt_valid[i]  = ($urandom_range(0, 3) != 0);
        rt_taken[i]  = ($urandom_range(0, 3) != 0);
        rt_btb_hit[i] = $urandom_range(0, 1) != 0;
        rt_pc[i]     = 32'($urandom_range(0, 7)) << 4;
        rt_target[i] = $urandom();
        rt_pred_target[i] = ($urandom_range(0, 1) != 0) ? rt_target[i] : 32'($urandom());
      end
      step();
    end
    set_idle();
    for (int c = 0; c < DEPTH + 2; c++) step();
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
